// File: rtl/fc_acc_bank.sv
// Multi-lane partial-sum accumulator: accumulates psums across input tiles in RAM,
// then drains requantised (round, ReLU, saturate) results through a valid/ready port.
module fc_acc_bank #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned PSUM_W = 16,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned OUT_W  = 8,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned NODE_W = $clog2(DEPTH) + 1,
  parameter int unsigned TILE_W = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [LANES*PSUM_W-1:0]   psum_i,
  input  logic                      pvalid_i,
  input  logic [NODE_W-1:0]         out_node_num_i,
  input  logic [TILE_W-1:0]         tile_num_i,
  input  logic [4:0]                shift_i,
  input  logic                      relu_en_i,
  output logic                      fc_valid_o,
  input  logic                      fc_ready_i,
  output logic [LANES*OUT_W-1:0]    fc_result_o,
  output logic                      last_o,
  output logic                      busy_o,
  output logic                      err_o
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned RAM_W = LANES * ACC_W;
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_FLUSH, S_DRAIN} state_t;

  state_t               state;
  logic [NODE_W-1:0]    cfg_n, n_cnt, cur_n, n_lim;
  logic [TILE_W-1:0]    cfg_t, t_cnt, cur_t, t_lim;
  logic [4:0]           cfg_shift;
  logic                 cfg_relu;
  logic                 idle, accept, node_wrap, last_beat;

  logic                 s1_valid, s1_first, byp_q;
  logic [AW-1:0]        s1_addr, rd_addr;
  logic [LANES*PSUM_W-1:0] s1_psum;
  logic [RAM_W-1:0]     byp_data, ram_q, old_word, wdata;
  logic [RAM_W-1:0]     mem [DEPTH];

  logic                 rd_inflight, rd_last, sk_valid, sk_last;
  logic [LANES*OUT_W-1:0] sk_data, push_res;
  logic                 pop, drain_rd, rd_en;
  logic [1:0]           occ_net;

  // Round-half-up shift, optional ReLU, saturate to OUT_W; one guard bit keeps the rounding add exact.
  function automatic logic [OUT_W-1:0] requant(input logic signed [ACC_W-1:0] acc,
                                               input logic [4:0] sh, input logic relu);
    logic signed [ACC_W:0] wide, rnd, r;
    wide = {acc[ACC_W-1], acc};
    rnd  = (sh != 5'd0) ? ((ACC_W+1)'(1) << (sh - 5'd1)) : '0;
    r    = (wide + rnd) >>> sh;
    if (relu && r[ACC_W]) r = '0;
    if (r > SAT_MAX) r = SAT_MAX;
    else if (r < SAT_MIN) r = SAT_MIN;
    return r[OUT_W-1:0];
  endfunction

  // In IDLE the start beat is treated as node 0 / tile 0 against the live config inputs.
  always_comb begin
    idle      = (state == S_IDLE);
    n_lim     = idle ? out_node_num_i : cfg_n;
    t_lim     = idle ? tile_num_i : cfg_t;
    cur_n     = idle ? '0 : n_cnt;
    cur_t     = idle ? '0 : t_cnt;
    accept    = pvalid_i && (idle || (state == S_ACC));
    node_wrap = (cur_n == n_lim - NODE_W'(1));
    last_beat = node_wrap && (cur_t == t_lim - TILE_W'(1));
  end

  // Drain issue counts occupancy net of this cycle's pop so a streaming drain sustains 1 beat/cycle.
  always_comb begin
    pop      = fc_valid_o && fc_ready_i;
    occ_net  = 2'(fc_valid_o) + 2'(sk_valid) - 2'(pop) + 2'(rd_inflight);
    drain_rd = (state == S_DRAIN) && (n_cnt < cfg_n) && (occ_net < 2'd2);
    rd_en    = accept || drain_rd;
    rd_addr  = accept ? cur_n[AW-1:0] : n_cnt[AW-1:0];
  end

  // Write-back data for the pending RMW; first tile ignores RAM, bypass covers same-address reads.
  always_comb begin
    old_word = byp_q ? byp_data : ram_q;
    wdata    = '0;
    push_res = '0;
    for (int k = 0; k < LANES; k++) begin
      wdata[k*ACC_W +: ACC_W] = (s1_first ? ACC_W'(0) : old_word[k*ACC_W +: ACC_W])
                              + {{(ACC_W-PSUM_W){s1_psum[k*PSUM_W+PSUM_W-1]}},
                                 s1_psum[k*PSUM_W +: PSUM_W]};
      push_res[k*OUT_W +: OUT_W] = requant(ram_q[k*ACC_W +: ACC_W], cfg_shift, cfg_relu);
    end
  end

  always_ff @(posedge clk) begin
    if (s1_valid) mem[s1_addr] <= wdata;
    if (rd_en) ram_q <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      n_cnt       <= '0;
      t_cnt       <= '0;
      cfg_n       <= '0;
      cfg_t       <= '0;
      cfg_shift   <= '0;
      cfg_relu    <= 1'b0;
      busy_o      <= 1'b0;
      err_o       <= 1'b0;
      s1_valid    <= 1'b0;
      s1_first    <= 1'b0;
      s1_addr     <= '0;
      s1_psum     <= '0;
      byp_q       <= 1'b0;
      byp_data    <= '0;
      rd_inflight <= 1'b0;
      rd_last     <= 1'b0;
      sk_valid    <= 1'b0;
      sk_data     <= '0;
      sk_last     <= 1'b0;
      fc_valid_o  <= 1'b0;
      fc_result_o <= '0;
      last_o      <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_addr  <= cur_n[AW-1:0];
        s1_psum  <= psum_i;
        s1_first <= (cur_t == '0);
      end
      byp_q       <= accept && s1_valid && (s1_addr == cur_n[AW-1:0]);
      byp_data    <= wdata;
      rd_inflight <= drain_rd;
      rd_last     <= (n_cnt == cfg_n - NODE_W'(1));

      // Two-entry output FIFO: the output registers are the head, sk_* the second slot.
      if (!fc_valid_o || pop) begin
        if (sk_valid) begin
          fc_valid_o  <= 1'b1;
          fc_result_o <= sk_data;
          last_o      <= sk_last;
          sk_valid    <= rd_inflight;
        end else if (rd_inflight) begin
          fc_valid_o  <= 1'b1;
          fc_result_o <= push_res;
          last_o      <= rd_last;
        end else begin
          fc_valid_o  <= 1'b0;
          last_o      <= 1'b0;
        end
        if (rd_inflight) begin
          sk_data <= push_res;
          sk_last <= rd_last;
        end
      end else if (rd_inflight) begin
        sk_valid <= 1'b1;
        sk_data  <= push_res;
        sk_last  <= rd_last;
      end

      case (state)
        S_IDLE, S_ACC: begin
          if (accept) begin
            if (idle) begin
              cfg_n     <= out_node_num_i;
              cfg_t     <= tile_num_i;
              cfg_shift <= shift_i;
              cfg_relu  <= relu_en_i;
              err_o     <= 1'b0;
            end
            busy_o <= 1'b1;
            if (last_beat) begin
              n_cnt <= '0;
              t_cnt <= '0;
              state <= S_FLUSH;
            end else if (node_wrap) begin
              n_cnt <= '0;
              t_cnt <= cur_t + TILE_W'(1);
              state <= S_ACC;
            end else begin
              n_cnt <= cur_n + NODE_W'(1);
              t_cnt <= cur_t;
              state <= S_ACC;
            end
          end
        end
        S_FLUSH: begin
          if (pvalid_i) err_o <= 1'b1;
          state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (pvalid_i) err_o <= 1'b1;
          if (drain_rd) n_cnt <= n_cnt + NODE_W'(1);
          if (pop && last_o) begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
            n_cnt  <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_acc_bank.sv
// Self-checking bench for fc_acc_bank: directed and random runs against a behavioural
// accumulate/requantise model, with backpressure, misuse and mid-run reset.
module tb_fc_acc_bank;

  localparam int LANES  = 4;
  localparam int PSUM_W = 16;
  localparam int ACC_W  = 32;
  localparam int OUT_W  = 8;
  localparam int DEPTH  = 1024;
  localparam int NODE_W = 11;
  localparam int TILE_W = 6;

  logic                    clk, rst_n;
  logic [LANES*PSUM_W-1:0] psum_i;
  logic                    pvalid_i;
  logic [NODE_W-1:0]       out_node_num_i;
  logic [TILE_W-1:0]       tile_num_i;
  logic [4:0]              shift_i;
  logic                    relu_en_i;
  logic                    fc_valid_o, fc_ready_i, last_o, busy_o, err_o;
  logic [LANES*OUT_W-1:0]  fc_result_o;

  fc_acc_bank #(.LANES(LANES), .PSUM_W(PSUM_W), .ACC_W(ACC_W), .OUT_W(OUT_W),
                .DEPTH(DEPTH), .NODE_W(NODE_W), .TILE_W(TILE_W)) dut (
    .clk(clk), .rst_n(rst_n), .psum_i(psum_i), .pvalid_i(pvalid_i),
    .out_node_num_i(out_node_num_i), .tile_num_i(tile_num_i), .shift_i(shift_i),
    .relu_en_i(relu_en_i), .fc_valid_o(fc_valid_o), .fc_ready_i(fc_ready_i),
    .fc_result_o(fc_result_o), .last_o(last_o), .busy_o(busy_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert, n_fail;
  logic [LANES*PSUM_W-1:0] stim[$];
  logic [LANES*OUT_W-1:0]  rx[$];
  logic [LANES*PSUM_W-1:0] w;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  // Reference requantisation from the arithmetic definition.
  function automatic longint rq(longint a, int s, bit relu);
    longint r;
    if (s > 0) r = (a + (longint'(1) << (s - 1))) >>> s;
    else r = a;
    if (relu && r < 0) r = 0;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return r;
  endfunction

  // Expected output word for one node: sum over all tiles, wrapped to 32 bits, then requantised.
  function automatic logic [LANES*OUT_W-1:0] model_node(int node, int n, int t, int s, bit relu);
    logic [LANES*OUT_W-1:0] v;
    longint sum;
    v = '0;
    for (int k = 0; k < LANES; k++) begin
      sum = 0;
      for (int tt = 0; tt < t; tt++)
        sum += longint'($signed(stim[tt*n+node][k*PSUM_W +: PSUM_W]));
      sum = longint'(int'(sum));
      v[k*OUT_W +: OUT_W] = OUT_W'(rq(sum, s, relu));
    end
    return v;
  endfunction

  task automatic run_job(input int n, input int t, input int s, input bit relu,
                         input bit gaps, input bit rand_ready, input bit inject_err,
                         input string tag);
    int got, cyc, first_cyc, last_cyc, budget;
    bit prev_stall, prev_last;
    logic [LANES*OUT_W-1:0] prev_res;
    rx.delete();
    for (int i = 0; i < n * t; i++) begin
      @(negedge clk);
      if (i == 0) chk({tag, "_idle"}, {busy_o, fc_valid_o}, 2'b00);
      if (i == 1) chk({tag, "_busy_err"}, {busy_o, err_o}, 2'b10);
      if (gaps && i > 0 && $urandom_range(0, 2) == 0) begin
        pvalid_i = 1'b0;
        psum_i   = {$urandom, $urandom};
        @(negedge clk);
      end
      pvalid_i       = 1'b1;
      psum_i         = stim[i];
      out_node_num_i = (i == 0) ? NODE_W'(n) : NODE_W'($urandom);
      tile_num_i     = (i == 0) ? TILE_W'(t) : TILE_W'($urandom);
      shift_i        = (i == 0) ? 5'(s) : 5'($urandom);
      relu_en_i      = (i == 0) ? relu : 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    cyc = 1; got = 0; first_cyc = -1; last_cyc = -1; prev_stall = 1'b0;
    prev_last = 1'b0; prev_res = '0;
    budget = 40 + 8 * n;
    while (got < n && cyc < budget) begin
      if (inject_err && (cyc == 1 || cyc == 2)) begin
        pvalid_i = 1'b1;
        psum_i   = {$urandom, $urandom};
      end else begin
        pvalid_i = 1'b0;
      end
      if (prev_stall)
        chk({tag, "_hold"}, {fc_valid_o, last_o, fc_result_o}, {1'b1, prev_last, prev_res});
      if (fc_valid_o && first_cyc < 0) first_cyc = cyc;
      fc_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (fc_valid_o && fc_ready_i) begin
        rx.push_back(fc_result_o);
        chk($sformatf("%s_data%0d", tag, got), fc_result_o, model_node(got, n, t, s, relu));
        chk($sformatf("%s_last%0d", tag, got), last_o, (got == n - 1));
        last_cyc = cyc;
        got++;
      end
      prev_stall = fc_valid_o && !fc_ready_i;
      prev_res   = fc_result_o;
      prev_last  = last_o;
      if (got < n) begin
        @(negedge clk);
        cyc++;
      end
    end
    chk({tag, "_count"}, got, n);
    chk({tag, "_latency"}, first_cyc, 4);
    if (!rand_ready) chk({tag, "_stream"}, last_cyc - first_cyc, n - 1);
    chk({tag, "_err"}, err_o, inject_err);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_assert = 0; n_fail = 0;
    rst_n = 1'b0; pvalid_i = 1'b0; psum_i = '0; fc_ready_i = 1'b0;
    out_node_num_i = '0; tile_num_i = '0; shift_i = '0; relu_en_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", fc_valid_o, 1'b0);
    chk("rst_last", last_o, 1'b0);
    chk("rst_result", fc_result_o, '0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    rst_n = 1'b1;

    // Basic run: lane0 carries 1,2,3 then 10,20,30.
    stim.delete();
    for (int t = 0; t < 2; t++)
      for (int n = 0; n < 3; n++) begin
        w = {$urandom, $urandom};
        w[PSUM_W-1:0] = PSUM_W'((t == 0 ? 1 : 10) * (n + 1));
        stim.push_back(w);
      end
    run_job(3, 2, 0, 1'b0, 1'b0, 1'b0, 1'b0, "basic");
    chk("basic_l0_n0", rx[0][OUT_W-1:0], 8'd11);
    chk("basic_l0_n1", rx[1][OUT_W-1:0], 8'd22);
    chk("basic_l0_n2", rx[2][OUT_W-1:0], 8'd33);

    // Hazard: single node, eight back-to-back tiles of +5.
    stim.delete();
    for (int i = 0; i < 8; i++) stim.push_back({LANES{16'd5}});
    run_job(1, 8, 0, 1'b0, 1'b0, 1'b0, 1'b0, "hazard");
    chk("hazard_val", rx[0], {LANES{8'd40}});

    // Requantisation and saturation, without then with ReLU.
    stim.delete();
    stim.push_back({LANES{16'sd6}});
    stim.push_back({LANES{-16'sd6}});
    stim.push_back({LANES{16'sd1000}});
    stim.push_back({LANES{-16'sd1000}});
    run_job(4, 1, 2, 1'b0, 1'b0, 1'b0, 1'b0, "rq");
    chk("rq_n0", rx[0][OUT_W-1:0], 8'd2);
    chk("rq_n1", rx[1][OUT_W-1:0], 8'hFF);
    chk("rq_n2", rx[2][OUT_W-1:0], 8'd127);
    chk("rq_n3", rx[3][OUT_W-1:0], 8'h80);
    run_job(4, 1, 2, 1'b1, 1'b0, 1'b0, 1'b0, "rqrelu");
    chk("rqrelu_n0", rx[0][OUT_W-1:0], 8'd2);
    chk("rqrelu_n1", rx[1][OUT_W-1:0], 8'd0);
    chk("rqrelu_n2", rx[2][OUT_W-1:0], 8'd127);
    chk("rqrelu_n3", rx[3][OUT_W-1:0], 8'd0);

    // Backpressure with random ready and gaps on the input.
    stim.delete();
    for (int i = 0; i < 16; i++) stim.push_back({$urandom, $urandom});
    run_job(8, 2, 3, 1'b0, 1'b1, 1'b1, 1'b0, "bp");

    // Misuse: pvalid during flush/drain, then a fresh run clears err.
    stim.delete();
    for (int i = 0; i < 10; i++) stim.push_back({$urandom, $urandom});
    run_job(5, 2, 1, 1'b0, 1'b0, 1'b0, 1'b1, "misuse");
    stim.delete();
    for (int i = 0; i < 9; i++) stim.push_back({$urandom, $urandom});
    run_job(3, 3, 4, 1'b1, 1'b0, 1'b0, 1'b0, "recover");

    // Reset in the middle of accumulation, then a short clean run.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pvalid_i = 1'b1; psum_i = {$urandom, $urandom};
      out_node_num_i = NODE_W'(4); tile_num_i = TILE_W'(3);
      shift_i = 5'd0; relu_en_i = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b0; pvalid_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_state", {busy_o, fc_valid_o, err_o}, 3'b000);
    stim.delete();
    stim.push_back({LANES{16'sd7}});
    stim.push_back({LANES{-16'sd3}});
    run_job(2, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, "midrst");
    chk("midrst_n0", rx[0][OUT_W-1:0], 8'd7);
    chk("midrst_n1", rx[1][OUT_W-1:0], 8'hFD);

    // Random runs, including single-node and single-tile corners.
    for (int j = 0; j < 6; j++) begin
      int rn, rt, rs;
      bit rr;
      rn = (j == 0) ? 1 : $urandom_range(1, 10);
      rt = (j == 0) ? 1 : $urandom_range(1, 5);
      rs = $urandom_range(0, 12);
      rr = 1'($urandom_range(0, 1));
      stim.delete();
      for (int i = 0; i < rn * rt; i++) stim.push_back({$urandom, $urandom});
      run_job(rn, rt, rs, rr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
              $sformatf("rand%0d", j));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fc_acc_bank.md
# fc_acc_bank

Parametrised multi-lane partial-sum accumulator for the fully-connected path. It sits between the bottom row of the systolic array (LANES columns) and the activation/writeback stage. It accumulates per-output-node partial sums across input tiles in an internal RAM. It then drains requantised results (rounding shift, optional ReLU, saturation) through a valid/ready output port with backpressure.

## Interface
- LANES, 4, number of systolic columns processed in parallel
- PSUM_W, 16, signed partial-sum width per lane
- ACC_W, 32, signed accumulator width per lane
- OUT_W, 8, signed output width per lane
- DEPTH, 1024, accumulator entries (output nodes per lane)
- NODE_W, $clog2(DEPTH)+1, width of node-count config
- TILE_W, 6, width of tile-count config
- clk  in  1  clock; all logic rising-edge
- rst_n  in  1  reset, synchronous, active-low
- psum_i  in  LANES*PSUM_W  signed partial sums, lane k at bits [k*PSUM_W +: PSUM_W]
- pvalid_i  in  1  psum_i valid this cycle
- out_node_num_i  in  NODE_W  nodes per tile N, 1..DEPTH, sampled on the start beat
- tile_num_i  in  TILE_W  tiles T, ≥1, sampled on the start beat
- shift_i  in  5  requant right shift S, 0..ACC_W-1, sampled on the start beat
- relu_en_i  in  1  clamp negatives to 0, sampled on the start beat
- fc_valid_o  out  1  output beat valid
- fc_ready_i  in  1  downstream accepts beat
- fc_result_o  out  LANES*OUT_W  requantised results, same lane packing
- last_o  out  1  marks beat for node N-1
- busy_o  out  1  high in every state except S_IDLE
- err_o  out  1  sticky: pvalid_i seen in S_FLUSH/S_DRAIN; cleared on next start beat

## Operation
- States: S_IDLE, S_ACC, S_FLUSH, S_DRAIN.
- S_IDLE: pvalid_i high is the start beat. It latches the config, processes the beat as node 0, tile 0, and moves to S_ACC.
- S_ACC accepts one beat per cycle when pvalid_i is high. Gaps are allowed.
- Counters: node counter n runs 0..N-1. Tile counter t increments when n wraps.
- Accepting beat (t=T-1, n=N-1) moves to S_FLUSH.
- Accumulate rule, per lane: the new entry is the sign-extended psum plus the old entry. The old entry is forced to 0 when t=0, so stale RAM is never read as data.
- The addition wraps in two's complement at ACC_W bits. There is no saturation at this stage.
- RAM is simple dual-port, DEPTH x LANES*ACC_W, with 1-cycle read latency. Read-modify-write is pipelined: read at acceptance cycle, write one cycle later.
- Write→read hazard (e.g. N=1, back-to-back beats): a one-entry bypass substitutes the in-flight write data whenever the read address matches the pending write address. Results must be exact for every N ≥ 1.
- S_FLUSH: completes the last pending write (1 cycle), then moves to S_DRAIN.
- S_DRAIN: reads nodes 0..N-1 in order into a 2-entry output FIFO. A read is issued only when FIFO occupancy plus in-flight reads is less than 2.
- Requant applies per lane on the FIFO input:
  - If S>0: r = (acc + 2^(S-1)) >>> S, which rounds half up.
  - If S=0: r = acc.
  - If relu_en, negative r becomes 0.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- last_o is asserted with the node N-1 beat. When that beat handshakes (fc_valid_o & fc_ready_i), the block returns to S_IDLE.
- pvalid_i in S_FLUSH/S_DRAIN: the beat is dropped and err_o is set.
- Reset mid-operation: next cycle is S_IDLE, FIFO empty, counters 0. RAM contents are don't-care.

## Timing
- Reset values: fc_valid_o=0, last_o=0, fc_result_o=0, busy_o=0, err_o=0.
- Accumulate throughput is 1 beat/cycle with no stall input. The upstream must never be backpressured.
- Drain start: the last beat is accepted at cycle L. S_FLUSH runs at L+1. The first read is issued at L+2. fc_valid_o is first high at L+4 (read plus FIFO register).
- Drain rate: with fc_ready_i held high, the N beats appear on N consecutive cycles.
- Backpressure: when fc_ready_i is low, fc_valid_o, fc_result_o and last_o hold stable. Per the valid/ready rule, fc_valid_o must not drop before the handshake.
- S_IDLE re-entry: the cycle after the last handshake. A start beat is accepted in that same cycle.
- A start beat on the same edge as the rst_n release is ignored.

## Test plan
- Basic run, LANES=4, N=3, T=2, S=0, no ReLU. Lane0 psums are 1,2,3 then 10,20,30. Required response: outputs 11,22,33 with last_o on 33, and outputs first valid at L+4.
- Hazard, N=1, T=8. Every beat is psum=+5 on all lanes. Required response: one beat of 40 (127 if OUT_W=8 and the sum exceeds 127, else exact). Bypass is exercised on every beat.
- Requant and saturation, N=4, T=1, S=2. psums are 6, -6, 1000, -1000.
  - relu_en=0: required outputs 2, -1, 127, -128.
  - relu_en=1: required outputs 2, 0, 127, 0.
- Backpressure, N=8. fc_ready_i toggles randomly. Required response: all 8 values in order, none duplicated or lost, outputs stable while stalled, and last_o only on the 8th beat.
- Misuse and recovery:
  - Assert pvalid_i during S_DRAIN. Required response: err_o=1 and results unaffected.
  - Then start a new run. Required response: err_o clears on the start beat.
- Assert rst_n low mid-S_ACC, then run N=2, T=1 with psums 7 and -3. Required response: outputs 7 and -3, no stale data.
